// File: rtl/npc_mem_pkg.sv
// Shared definitions for the core's data-memory port: size masks, arbiter
// state encoding and requester identifiers.
package npc_mem_pkg;

    localparam logic [3:0] MASK_D = 4'b0001;
    localparam logic [3:0] MASK_W = 4'b0010;
    localparam logic [3:0] MASK_H = 4'b0100;
    localparam logic [3:0] MASK_B = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_align_chk.sv
// Size/alignment legality of a memory access: the mask must be one-hot and
// the low address bits must be zero for the selected access size.
module mem_align_chk
    import npc_mem_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [2:0] addr,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (mask)
            MASK_D:  legal = (addr == 3'b000);
            MASK_W:  legal = (addr[1:0] == 2'b00);
            MASK_H:  legal = ~addr[0];
            MASK_B:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for the single
// data-memory port; one transaction in flight, one enable cycle per access.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_mask,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_ena,
    output logic        mem_wen,
    output logic [3:0]  mem_mask,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state, state_nxt;
    req_id_t           last_grant, req;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       addr_q, wdata_q, rdata_q;
    logic [3:0]        mask_q;
    logic              wen_q, err_q;

    logic              grant_ifu, grant_lsu;
    logic              acc_ifu, acc_lsu, accept;
    logic              legal, mem_fire, resp_hs;
    logic [3:0]        chk_mask;
    logic [2:0]        chk_addr;

    // On a tie the requester that was not served last wins.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == REQ_IFU);
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    assign acc_ifu  = ifu_req_valid && ifu_req_ready;
    assign acc_lsu  = lsu_req_valid && lsu_req_ready;
    assign accept   = acc_ifu || acc_lsu;
    assign chk_mask = acc_lsu ? lsu_mask : MASK_W;
    assign chk_addr = acc_lsu ? lsu_addr[2:0] : ifu_addr[2:0];
    assign mem_fire = (state == ACCESS) && (cnt == '0);
    assign resp_hs  = (state == RESP) &&
                      ((req == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready);

    mem_align_chk u_align_chk (
        .mask  (chk_mask),
        .addr  (chk_addr),
        .legal (legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = legal ? ACCESS : RESP;
            ACCESS:  if (mem_fire) state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ_IFU;
            req        <= REQ_IFU;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mask_q     <= '0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                req     <= acc_lsu ? REQ_LSU : REQ_IFU;
                addr_q  <= acc_lsu ? lsu_addr : ifu_addr;
                mask_q  <= chk_mask;
                wen_q   <= acc_lsu && lsu_wen;
                wdata_q <= acc_lsu ? lsu_wdata : 64'd0;
                cnt     <= CNT_W'(MEM_LAT - 1);
                err_q   <= !legal;
                rdata_q <= '0;
            end
            if (state == ACCESS) begin
                if (cnt == '0) rdata_q <= wen_q ? 64'd0 : mem_rdata;
                else           cnt     <= cnt - CNT_W'(1);
            end
            if (resp_hs) last_grant <= req;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        ifu_req_ready  = rst_n && (state == IDLE) && grant_ifu;
        lsu_req_ready  = rst_n && (state == IDLE) && grant_lsu;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_err        = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_err        = 1'b0;
        mem_ena        = 1'b0;
        mem_wen        = 1'b0;
        mem_mask       = '0;
        mem_addr       = '0;
        mem_wdata      = '0;
        if (mem_fire) begin
            mem_ena   = 1'b1;
            mem_wen   = wen_q;
            mem_mask  = mask_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state == RESP) begin
            if (req == REQ_IFU) begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = rdata_q;
                ifu_err        = err_q;
            end else begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = rdata_q;
                lsu_err        = err_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of the
// grant order, legality rules, access latency and response data.
module tb_mem_arbiter;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
    logic [3:0]  lsu_mask;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_ena, mem_wen;
    logic [3:0]  mem_mask;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [12:0] outs_flat;

    int checks = 0;
    int errors = 0;
    bit model_last_lsu = 1'b0;
    logic [63:0] exp_q[$];

    mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_mask(lsu_mask), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    assign mem_rdata = mem_model(mem_addr);
    assign outs_flat = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                        ifu_err, lsu_err, mem_ena, mem_wen, |mem_mask, |mem_addr,
                        |mem_wdata, |ifu_rdata, |lsu_rdata};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker / model ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal_ref(input logic [3:0] m, input logic [63:0] a);
        int size;
        if ($countones(m) != 1) return 1'b0;
        size = m[0] ? 8 : (m[1] ? 4 : (m[2] ? 2 : 1));
        return (a % size) == 0;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_idle();
        ifu_req_valid  = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0; lsu_wen = 1'b0; lsu_mask = '0;
        lsu_addr       = '0;   lsu_wdata = '0; lsu_resp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outs", 64'(outs_flat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last_lsu = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_txn(input bit use_ifu, input bit use_lsu, input bit wen,
                           input logic [3:0] mask, input logic [63:0] iaddr,
                           input logic [63:0] laddr, input logic [63:0] wdata, input int hold);
        bit lsu_win, legal, w, exp_ena, g_rdy, o_rdy;
        logic [63:0] a;
        logic [3:0] m;
        int resp_at;
        @(negedge clk);
        drive_idle();
        ifu_req_valid = use_ifu; ifu_addr = iaddr;
        lsu_req_valid = use_lsu; lsu_wen = wen; lsu_mask = mask;
        lsu_addr = laddr; lsu_wdata = wdata;
        lsu_win = use_lsu && (!use_ifu || !model_last_lsu);
        #1;
        check("idle_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        check("idle_ena", 64'(mem_ena), 64'd0);
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(use_ifu && !lsu_win));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(lsu_win));
        if ((lsu_win ? lsu_req_ready : ifu_req_ready) !== 1'b1) begin
            apply_reset();
            return;
        end
        a = lsu_win ? laddr : iaddr;
        m = lsu_win ? mask : 4'b0010;
        w = lsu_win && wen;
        legal = legal_ref(m, a);
        exp_q.push_back((legal && !w) ? mem_model(a) : 64'd0);
        resp_at = legal ? MEM_LAT + 1 : 1;
        for (int k = 1; k <= resp_at + hold; k++) begin
            @(negedge clk);
            ifu_req_valid = 1'($urandom_range(0, 1)); ifu_addr = {$urandom, $urandom};
            lsu_req_valid = 1'($urandom_range(0, 1)); lsu_wen = 1'($urandom_range(0, 1));
            lsu_mask = 4'($urandom); lsu_addr = {$urandom, $urandom};
            lsu_wdata = {$urandom, $urandom};
            g_rdy = (k == resp_at + hold) ? 1'b1 :
                    ((k < resp_at) ? 1'($urandom_range(0, 1)) : 1'b0);
            o_rdy = 1'($urandom_range(0, 1));
            lsu_resp_ready = lsu_win ? g_rdy : o_rdy;
            ifu_resp_ready = lsu_win ? o_rdy : g_rdy;
            #1;
            exp_ena = legal && (k == MEM_LAT);
            check("mem_ena", 64'(mem_ena), 64'(exp_ena));
            if (exp_ena) begin
                check("mem_wen", 64'(mem_wen), 64'(w));
                check("mem_mask", 64'(mem_mask), 64'(m));
                check("mem_addr", mem_addr, a);
                if (w) check("mem_wdata", mem_wdata, wdata);
            end else begin
                check("mem_quiet", 64'({mem_wen, |mem_mask, |mem_addr, |mem_wdata}), 64'd0);
            end
            check("busy_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
            check("resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}),
                  (k >= resp_at) ? (lsu_win ? 64'd1 : 64'd2) : 64'd0);
            if (k >= resp_at) begin
                check("resp_rdata", lsu_win ? lsu_rdata : ifu_rdata, exp_q[0]);
                check("resp_err", 64'(lsu_win ? lsu_err : ifu_err), 64'(!legal));
            end
        end
        void'(exp_q.pop_front());
        model_last_lsu = lsu_win;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        drive_idle();
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_mask = 4'b1000;
        lsu_addr = 64'h8000_0003; lsu_wdata = 64'hAB;
        #1 check("rm_accept", 64'(lsu_req_ready), 64'd1);
        @(negedge clk);
        drive_idle();
        #1 check("rm_ena_t1", 64'(mem_ena), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rm_ena_t2", 64'(mem_ena), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rm_outs", 64'(outs_flat), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check("rm_no_store", 64'({mem_ena, mem_wen, lsu_resp_valid}), 64'd0);
        end
        model_last_lsu = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ui, ul;
        int r;
        logic [3:0] msk;
        logic [63:0] ia;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outs", 64'(outs_flat), 64'd0);
        @(negedge clk);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_mask = 4'b0001;
        #1 check("reset_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1 check("post_reset_outs", 64'(outs_flat), 64'd0);

        run_txn(1, 0, 0, 4'b0000, 64'h8000_0000, 64'h0, 64'h0, 0);
        for (int i = 0; i < 3; i++)
            run_txn(1, 1, 0, 4'b0010, 64'h8000_0100 + 64'(i * 8), 64'h8000_0200 + 64'(i * 8), 64'h0, 1);
        run_txn(0, 1, 1, 4'b1000, 64'h0, 64'h8000_0003, 64'hAB, 0);
        run_txn(0, 1, 0, 4'b0010, 64'h0, 64'h8000_0002, 64'h0, 0);
        run_txn(0, 1, 0, 4'b0110, 64'h0, 64'h8000_0000, 64'h0, 0);
        run_txn(1, 1, 0, 4'b0001, 64'h8000_0010, 64'h8000_0040, 64'h0, 5);

        for (int i = 0; i < 40; i++) begin
            ui = 1'($urandom_range(0, 1));
            ul = 1'($urandom_range(0, 1));
            if (!ui && !ul) ul = 1'b1;
            r = $urandom_range(0, 9);
            msk = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom);
            ia = 64'h8000_0000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ia = ia & ~64'd3;
            run_txn(ui, ul, 1'($urandom_range(0, 1)), msk, ia,
                    64'h8000_0000 + 64'($urandom_range(0, 255)), {$urandom, $urandom},
                    $urandom_range(0, 3));
        end

        reset_mid();
        run_txn(1, 1, 0, 4'b0100, 64'h8000_0020, 64'h8000_0006, 64'h0, 0);
        run_txn(1, 1, 0, 4'b0100, 64'h8000_0024, 64'h8000_000A, 64'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
